// File: rtl/fifo_sync_flags_if.sv
// fifo_sync_flags_if: handshake/status bundle for the single-clock flagged FIFO.
//
// Signals:
//   flush, write, dataIn, read, err_clear      : producer/consumer -> FIFO
//   dataOut, rd_valid, count, full, empty,
//   almost_full, almost_empty, overflow,
//   underflow                                  : FIFO -> producer/consumer
//
// Modports:
//   master : the producer/consumer side (drives requests, observes status)
//   slave  : the FIFO itself
interface fifo_sync_flags_if #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH_LOG2 = 3
);
   logic                  flush;
   logic                  write;
   logic [WIDTH-1:0]      dataIn;
   logic                  read;
   logic                  err_clear;
   logic [WIDTH-1:0]      dataOut;
   logic                  rd_valid;
   logic [DEPTH_LOG2:0]   count;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, write, dataIn, read, err_clear,
      input  dataOut, rd_valid, count, full, empty, almost_full, almost_empty,
             overflow, underflow
   );

   modport slave (
      input  flush, write, dataIn, read, err_clear,
      output dataOut, rd_valid, count, full, empty, almost_full, almost_empty,
             overflow, underflow
   );
endinterface

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: parametrised single-clock FIFO with almost-full/almost-empty
// flags, sticky overflow/underflow errors, synchronous flush and a read-valid
// strobe. A full FIFO still accepts a write when a read is accepted that cycle.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fifo_sync_flags_if.slave (requests, read data, count and flags)
//
// Build option:
//   FIFO_FWFT_EN : first-word fall-through; dataOut/rd_valid show the head
//                  combinationally and read pops it. Undefined: registered
//                  read path with one cycle of latency.
module fifo_sync_flags #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned DEPTH_LOG2    = 3,
   parameter int unsigned AFULL_THRESH  = (2**DEPTH_LOG2)-1,
   parameter int unsigned AEMPTY_THRESH = 1
) (
   input logic              clk,
   input logic              rst,
   fifo_sync_flags_if.slave bus
);
   localparam int unsigned Depth = 2**DEPTH_LOG2;

   typedef logic [DEPTH_LOG2:0] ptr_t;

   localparam ptr_t PtrOne    = ptr_t'(1);
   localparam ptr_t DepthCnt  = ptr_t'(Depth);
   localparam ptr_t AfullCnt  = ptr_t'(AFULL_THRESH);
   localparam ptr_t AemptyCnt = ptr_t'(AEMPTY_THRESH);

`ifndef SYNTHESIS
   initial begin
      if (AFULL_THRESH == 0 || AFULL_THRESH > Depth)
         $error("fifo_sync_flags: AFULL_THRESH must lie in 1..%0d", Depth);
      if (AEMPTY_THRESH > Depth - 1)
         $error("fifo_sync_flags: AEMPTY_THRESH must lie in 0..%0d", Depth - 1);
   end
`endif

   logic [WIDTH-1:0] mem_q [Depth];

   ptr_t wptr_q, wptr_d;
   ptr_t rptr_q, rptr_d;
   ptr_t count;
   logic empty, full;
   logic rd_acc, wr_acc;
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   always_comb begin
      // Wrap bit makes the modular difference distinguish full from empty.
      count  = wptr_q - rptr_q;
      empty  = (count == '0);
      full   = (count == DepthCnt);
      // Flush overrides both requests and suppresses their error flags.
      rd_acc = bus.read & ~empty & ~bus.flush;
      wr_acc = bus.write & (~full | rd_acc) & ~bus.flush;

      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (bus.flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (wr_acc) wptr_d = wptr_q + PtrOne;
         if (rd_acc) rptr_d = rptr_q + PtrOne;
      end

      // A new error in the same cycle as err_clear wins.
      ovf_d = ovf_q;
      if (bus.err_clear) ovf_d = 1'b0;
      if (bus.write & ~wr_acc & ~bus.flush) ovf_d = 1'b1;

      udf_d = udf_q;
      if (bus.err_clear) udf_d = 1'b0;
      if (bus.read & empty & ~bus.flush) udf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

   // Storage carries no reset; contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= bus.dataIn;
   end

`ifdef FIFO_FWFT_EN
   always_comb begin
      bus.dataOut  = empty ? '0 : mem_q[rptr_q[DEPTH_LOG2-1:0]];
      bus.rd_valid = ~empty;
   end
`else
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             rv_q, rv_d;

   always_comb begin
      dout_d = rd_acc ? mem_q[rptr_q[DEPTH_LOG2-1:0]] : dout_q;
      rv_d   = rd_acc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q <= '0;
         rv_q   <= 1'b0;
      end else begin
         dout_q <= dout_d;
         rv_q   <= rv_d;
      end
   end

   always_comb begin
      bus.dataOut  = dout_q;
      bus.rd_valid = rv_q;
   end
`endif

   always_comb begin
      bus.count        = count;
      bus.full         = full;
      bus.empty        = empty;
      bus.almost_full  = (count >= AfullCnt);
      bus.almost_empty = (count <= AemptyCnt);
      bus.overflow     = ovf_q;
      bus.underflow    = udf_q;
   end
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: directed, table-driven bench for fifo_sync_flags
// (WIDTH=8, DEPTH_LOG2=2, AFULL_THRESH=3, AEMPTY_THRESH=1, registered read).
// Observed bundle per check: {dataOut, rd_valid, count, full, empty,
// almost_full, almost_empty, overflow, underflow}.
module tb_fifo_sync_flags;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   fifo_sync_flags_if #(.WIDTH(8), .DEPTH_LOG2(2)) bus_if ();

   fifo_sync_flags #(
      .WIDTH        (8),
      .DEPTH_LOG2   (2),
      .AFULL_THRESH (3),
      .AEMPTY_THRESH(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   typedef struct {
      logic        flush;
      logic        wr;
      logic [7:0]  din;
      logic        rd;
      logic        ec;
      logic [17:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic logic [17:0] mk(input logic [7:0] dout, input logic rv,
                                      input logic [2:0] cnt, input logic fu,
                                      input logic em, input logic af, input logic ae,
                                      input logic ov, input logic ud);
      return {dout, rv, cnt, fu, em, af, ae, ov, ud};
   endfunction

   function automatic logic [17:0] obs();
      return {bus_if.dataOut, bus_if.rd_valid, bus_if.count, bus_if.full, bus_if.empty,
              bus_if.almost_full, bus_if.almost_empty, bus_if.overflow, bus_if.underflow};
   endfunction

   task automatic check(input string name, input logic [17:0] exp);
      logic [17:0] act;
      act = obs();
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic add(input string name, input logic fl, input logic wr,
                      input logic [7:0] din, input logic rd, input logic ec,
                      input logic [17:0] exp);
      vec_t v;
      v.flush = fl; v.wr = wr; v.din = din; v.rd = rd; v.ec = ec;
      v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic fl, input logic wr, input logic [7:0] din,
                        input logic rd, input logic ec);
      bus_if.flush     = fl;
      bus_if.write     = wr;
      bus_if.dataIn    = din;
      bus_if.read      = rd;
      bus_if.err_clear = ec;
   endtask

   initial begin
      logic [17:0] rst_exp;
      rst_exp = mk(8'h00, 0, 3'd0, 0, 1, 0, 1, 0, 0);

      // name, flush, write, din, read, err_clear, expected bundle
      add("idle",       0, 0, 8'h00, 0, 0, rst_exp);
      add("wr11",       0, 1, 8'h11, 0, 0, mk(8'h00, 0, 3'd1, 0, 0, 0, 1, 0, 0));
      add("wr22",       0, 1, 8'h22, 0, 0, mk(8'h00, 0, 3'd2, 0, 0, 0, 0, 0, 0));
      add("wr33",       0, 1, 8'h33, 0, 0, mk(8'h00, 0, 3'd3, 0, 0, 1, 0, 0, 0));
      add("wr44",       0, 1, 8'h44, 0, 0, mk(8'h00, 0, 3'd4, 1, 0, 1, 0, 0, 0));
      add("ovf_wr55",   0, 1, 8'h55, 0, 0, mk(8'h00, 0, 3'd4, 1, 0, 1, 0, 1, 0));
      add("ovf_setwin", 0, 1, 8'h57, 0, 1, mk(8'h00, 0, 3'd4, 1, 0, 1, 0, 1, 0));
      add("ovf_clear",  0, 0, 8'h00, 0, 1, mk(8'h00, 0, 3'd4, 1, 0, 1, 0, 0, 0));
      add("full_rw66",  0, 1, 8'h66, 1, 0, mk(8'h11, 1, 3'd4, 1, 0, 1, 0, 0, 0));
      add("rd22",       0, 0, 8'h00, 1, 0, mk(8'h22, 1, 3'd3, 0, 0, 1, 0, 0, 0));
      add("rd33",       0, 0, 8'h00, 1, 0, mk(8'h33, 1, 3'd2, 0, 0, 0, 0, 0, 0));
      add("rd44",       0, 0, 8'h00, 1, 0, mk(8'h44, 1, 3'd1, 0, 0, 0, 1, 0, 0));
      add("rd66",       0, 0, 8'h00, 1, 0, mk(8'h66, 1, 3'd0, 0, 1, 0, 1, 0, 0));
      add("wrA0",       0, 1, 8'hA0, 0, 0, mk(8'h66, 0, 3'd1, 0, 0, 0, 1, 0, 0));
      // Six write/read pairs carry the pointers past the wrap point.
      for (int i = 1; i <= 6; i++)
         add($sformatf("wrap_pair%0d", i), 0, 1, 8'(8'hA0 + i), 1, 0,
             mk(8'(8'hA0 + i - 1), 1, 3'd1, 0, 0, 0, 1, 0, 0));
      add("rdA6",       0, 0, 8'h00, 1, 0, mk(8'hA6, 1, 3'd0, 0, 1, 0, 1, 0, 0));
      add("udf_rd",     0, 0, 8'h00, 1, 0, mk(8'hA6, 0, 3'd0, 0, 1, 0, 1, 0, 1));
      add("udf_setwin", 0, 0, 8'h00, 1, 1, mk(8'hA6, 0, 3'd0, 0, 1, 0, 1, 0, 1));
      add("udf_clear",  0, 0, 8'h00, 0, 1, mk(8'hA6, 0, 3'd0, 0, 1, 0, 1, 0, 0));
      add("wrB1",       0, 1, 8'hB1, 0, 0, mk(8'hA6, 0, 3'd1, 0, 0, 0, 1, 0, 0));
      add("wrB2",       0, 1, 8'hB2, 0, 0, mk(8'hA6, 0, 3'd2, 0, 0, 0, 0, 0, 0));
      add("wrB3",       0, 1, 8'hB3, 0, 0, mk(8'hA6, 0, 3'd3, 0, 0, 1, 0, 0, 0));
      add("flush_wr_rd",1, 1, 8'hB4, 1, 0, mk(8'hA6, 0, 3'd0, 0, 1, 0, 1, 0, 0));
      add("wrC1",       0, 1, 8'hC1, 0, 0, mk(8'hA6, 0, 3'd1, 0, 0, 0, 1, 0, 0));
      add("rdC1",       0, 0, 8'h00, 1, 0, mk(8'hC1, 1, 3'd0, 0, 1, 0, 1, 0, 0));

      drive(0, 0, 8'h00, 0, 0);
      #3;
      check("reset_async", rst_exp);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_held", rst_exp);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].flush, vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].ec);
         @(posedge clk);
         #1;
         check(vecs[i].name, vecs[i].exp);
      end

      // Mid-burst asynchronous reset: state clears between clock edges.
      drive(0, 1, 8'hD1, 0, 0);
      @(posedge clk); #1;
      drive(0, 1, 8'hD2, 0, 0);
      @(posedge clk); #1;
      drive(0, 1, 8'hD3, 1, 0);
      @(posedge clk); #1;
      check("burst_pre_rst", mk(8'hD1, 1, 3'd2, 0, 0, 0, 0, 0, 0));
      drive(0, 1, 8'hD4, 0, 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid_burst", rst_exp);
      @(posedge clk); #1;
      check("rst_hold_burst", rst_exp);
      drive(0, 0, 8'h00, 0, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_idle", rst_exp);
      // Contents are lost: first read after reset returns the new write.
      drive(0, 1, 8'hE1, 0, 0);
      @(posedge clk); #1;
      drive(0, 0, 8'h00, 1, 0);
      @(posedge clk); #1;
      check("post_rst_rdE1", mk(8'hE1, 1, 3'd0, 0, 1, 0, 1, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
